arm_fetch_unit: RTL
===================

Name: arm_fetch_unit

Overview:
- Instruction fetch stage feeding the decode stage and the register file's PC write port.
- Issues word-aligned reads to instruction memory and buffers returned words in an in-order prefetch queue.
- Presents each word to decode with its address; also presents the ARM-visible PC (address + 8) for r15.
- Handles branch redirects by flushing the queue and discarding in-flight responses.

Parameters:
- DEPTH, 4, prefetch queue entries; power of 2, minimum 2.
- RESET_PC, 32'h0000_0000, first fetch address after reset; low 2 bits ignored.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous active-low reset.
- mem_req_valid  output  1  fetch request valid.
- mem_req_ready  input  1  memory accepts request.
- mem_req_addr  output  32  word-aligned fetch address.
- mem_rsp_valid  input  1  read data valid; responses arrive in order, one per accepted request, never before the cycle after acceptance.
- mem_rsp_data  input  32  instruction word.
- branch_valid  input  1  one-cycle redirect strobe.
- branch_target  input  32  redirect address; low 2 bits forced to 0.
- instr_valid  output  1  queue head valid.
- instr_ready  input  1  decode consumes head.
- instr  output  32  head instruction word.
- instr_pc  output  32  address of head instruction.
- pc_next  output  32  instr_pc + 8, modulo 2^32; drives the register file PC input.

Behaviour:
- Reset (async assert, sync release): state IDLE, fetch_addr = {RESET_PC[31:2],2'b00}, outstanding = 0, count = 0, queue storage cleared.
- Outputs during reset: mem_req_valid = 0, instr_valid = 0, instr = 0, instr_pc = 0, pc_next = 8.
- States:
  - IDLE: no requests; goes to RUN on the first edge after reset release.
  - RUN: normal fetching.
  - DRAIN: discard in-flight responses after a redirect.
- Credit rule: mem_req_valid = (state == RUN) && (outstanding + count < DEPTH). It is combinational and never depends on mem_req_ready. Counters are clog2(DEPTH)+1 bits wide.
- mem_req_addr = fetch_addr. It holds while valid && !ready, except on a redirect, which may change or withdraw the request.
- Request handshake (valid && ready): fetch_addr += 4, wrapping 32'hFFFF_FFFC to 0; outstanding++.
- Response in RUN:
  - Written into the queue at the tail, with its address from an in-order address shadow.
  - outstanding--.
  - Space is always available because of the credit rule.
- Latency: response at edge M gives instr_valid = 1 after edge M. Back-to-back responses with instr_ready held high sustain 1 instruction/cycle.
- Queue head: instr, instr_pc and pc_next are read combinationally from the head entry. Handshake (instr_valid && instr_ready) pops the head (count--).
- Simultaneous push and pop: count unchanged. Pointers wrap modulo DEPTH.
- Redirect (branch_valid, any state other than IDLE), effects in the same edge:
  - Queue flushed (count = 0). A pop in the same cycle still counts as consumed.
  - fetch_addr = aligned branch_target. No request is issued in the redirect cycle, so a request handshake cannot coincide with it.
  - Responses arriving in the redirect cycle are discarded.
  - drop = outstanding minus 1 if a response arrives this cycle. If drop > 0, go to DRAIN; otherwise go to RUN.
- DRAIN:
  - Each response decrements outstanding and is discarded; no requests are issued; instr_valid = 0.
  - When outstanding reaches 0 (after the final discard), go to RUN.
  - A further branch_valid in DRAIN updates fetch_addr only and stays in DRAIN.
- branch_valid in IDLE: ignored.
- Reset mid-operation: all state returns to reset values immediately. Responses for pre-reset requests are outside this block's contract (memory is reset together with it).

Test Plan:
- Reset/startup: reset_n low 3 cycles, RESET_PC = 0x100, mem_req_ready = 1, 1-cycle response latency -> after release, requests to 0x100, 0x104, 0x108, 0x10C. instr_valid first rises on the edge after the first response, with instr_pc = 0x100 and pc_next = 0x108.
- Backpressure: instr_ready = 0, DEPTH = 4 -> exactly 4 requests accepted, then mem_req_valid = 0. Raise instr_ready -> 4 pops in order, and requests resume after the first pop.
- Redirect with in-flight reads: 2 outstanding, branch_valid with target 0x2003 -> queue empties and the 2 responses are discarded. Next request is 0x2000; next instr_pc = 0x2000.
- Redirect coinciding with pop and response: branch cycle has instr handshake plus one of 2 outstanding responses -> popped word is consumed, the response is dropped, 1 more response is dropped in DRAIN, then RUN.
- Address wrap: RESET_PC = 0xFFFF_FFF8 -> requests 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0. For the head at 0xFFFF_FFFC, pc_next = 0x4.
- Async reset during DRAIN: assert reset_n mid-cycle -> mem_req_valid and instr_valid drop immediately. After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/arm_fetch_unit_if.sv
// arm_fetch_unit_if: fetch-unit bus bundle: memory request/response, branch redirect, decode handoff.
// Latency: none (wires only).
// Backpressure: mem_req_ready stalls requests, instr_ready stalls the decode handoff.
// Ports (master = fetch unit side):
//   mem_req_valid/mem_req_ready/mem_req_addr   fetch request channel
//   mem_rsp_valid/mem_rsp_data                 in-order read data
//   branch_valid/branch_target                 one-cycle redirect strobe
//   instr_valid/instr_ready/instr/instr_pc     decode handoff of the queue head
//   pc_next                                    instr_pc + 8 for r15
interface arm_fetch_unit_if;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        branch_valid;
  logic [31:0] branch_target;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] pc_next;

  modport master (
    output mem_req_valid, mem_req_addr,
    input  mem_req_ready,
    input  mem_rsp_valid, mem_rsp_data,
    input  branch_valid, branch_target,
    output instr_valid, instr, instr_pc, pc_next,
    input  instr_ready
  );

  modport slave (
    input  mem_req_valid, mem_req_addr,
    output mem_req_ready,
    output mem_rsp_valid, mem_rsp_data,
    output branch_valid, branch_target,
    input  instr_valid, instr, instr_pc, pc_next,
    output instr_ready
  );
endinterface

// File: rtl/arm_fetch_unit.sv
// arm_fetch_unit: word-aligned instruction fetch with in-order prefetch queue, redirect flush and drain.
// Latency: response at edge M -> instr_valid after edge M; back-to-back responses sustain 1 instr/cycle.
// Backpressure: requests only while outstanding + queued < DEPTH, so a stalled decode just holds the head.
// Ports:
//   clock    rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      arm_fetch_unit_if.master (memory request/response, branch redirect, decode handoff)
module arm_fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic             clock,
  input  logic             reset_n,
  arm_fetch_unit_if.master bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [31:0]   RESET_ADDR = {RESET_PC[31:2], 2'b00};
  localparam logic [CW:0]   DEPTH_W    = DEPTH[CW:0];
  localparam logic [CW-1:0] ONE_C      = 1;
  localparam logic [PW-1:0] ONE_P      = 1;

  logic [1:0]    state_q, state_d;
  logic [31:0]   fetch_addr_q, fetch_addr_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [31:0]   data_q [DEPTH];
  logic [31:0]   data_d [DEPTH];
  logic [31:0]   addr_q [DEPTH];
  logic [31:0]   addr_d [DEPTH];

  logic        redirect;
  logic        credit_ok;
  logic        req_vld;
  logic        req_hs;
  logic        instr_vld;
  logic        pop;
  logic        rsp_seen;
  logic        push;
  logic [31:0] rsp_addr;
  logic [31:0] target_aligned;

  // Redirects are only honoured once fetching has started.
  assign redirect       = bus.branch_valid && (state_q != ST_IDLE);
  assign target_aligned = bus.branch_target & 32'hFFFF_FFFC;

  // Credit check: every accepted request owns a queue slot until it is popped,
  // so a response can always be written without a full check.
  assign credit_ok = ({1'b0, outstanding_q} + {1'b0, count_q}) < DEPTH_W;
  // The redirect cycle never issues, so a handshake cannot race the new target.
  assign req_vld   = (state_q == ST_RUN) && credit_ok && !bus.branch_valid;
  assign req_hs    = req_vld && bus.mem_req_ready;

  assign instr_vld = (state_q == ST_RUN) && (count_q != '0);
  assign pop       = instr_vld && bus.instr_ready;

  assign rsp_seen  = bus.mem_rsp_valid && (state_q != ST_IDLE);
  assign push      = (state_q == ST_RUN) && bus.mem_rsp_valid && !redirect;

  // Address shadow: requests are sequential from fetch_addr and responses are in
  // order, so the oldest outstanding request sits 4*outstanding bytes behind.
  assign rsp_addr = fetch_addr_q - (32'(outstanding_q) << 2);

  assign bus.mem_req_valid = req_vld;
  assign bus.mem_req_addr  = fetch_addr_q;
  assign bus.instr_valid   = instr_vld;
  assign bus.instr         = data_q[rd_ptr_q];
  assign bus.instr_pc      = addr_q[rd_ptr_q];
  assign bus.pc_next       = addr_q[rd_ptr_q] + 32'd8;

  always_comb begin
    state_d       = state_q;
    fetch_addr_d  = fetch_addr_q;
    outstanding_d = outstanding_q;
    count_d       = count_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    data_d        = data_q;
    addr_d        = addr_q;

    if (req_hs && !rsp_seen) begin
      outstanding_d = outstanding_q + ONE_C;
    end else if (!req_hs && rsp_seen) begin
      outstanding_d = outstanding_q - ONE_C;
    end

    case (state_q)
      ST_IDLE: begin
        state_d = ST_RUN;
      end

      ST_RUN: begin
        if (redirect) begin
          // Flush: a same-cycle pop is simply consumed, a same-cycle response is dropped.
          count_d      = '0;
          wr_ptr_d     = '0;
          rd_ptr_d     = '0;
          fetch_addr_d = target_aligned;
          state_d      = (outstanding_d != '0) ? ST_DRAIN : ST_RUN;
        end else begin
          if (req_hs) begin
            fetch_addr_d = fetch_addr_q + 32'd4;
          end
          if (push) begin
            data_d[wr_ptr_q] = bus.mem_rsp_data;
            addr_d[wr_ptr_q] = rsp_addr;
            wr_ptr_d         = wr_ptr_q + ONE_P;
          end
          if (pop) begin
            rd_ptr_d = rd_ptr_q + ONE_P;
          end
          if (push && !pop) begin
            count_d = count_q + ONE_C;
          end else if (!push && pop) begin
            count_d = count_q - ONE_C;
          end
        end
      end

      ST_DRAIN: begin
        // Stale responses only decrement outstanding; a new redirect just retargets.
        if (bus.branch_valid) begin
          fetch_addr_d = target_aligned;
        end
        state_d = (outstanding_d == '0) ? ST_RUN : ST_DRAIN;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      fetch_addr_q  <= RESET_ADDR;
      outstanding_q <= '0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        addr_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      fetch_addr_q  <= fetch_addr_d;
      outstanding_q <= outstanding_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      data_q        <= data_d;
      addr_q        <= addr_d;
    end
  end

endmodule
